// File: rtl/md_unit_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : md_unit_ctrl
// Description : Multi-cycle mult/div sequencer owning HI/LO, with D-stage
//               stall request for the hazard unit.
// Revision    : 1.0
// =============================================================================
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic              busy_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    logic              w_is_arith;
    logic              w_is_mult;
    logic              w_accept;
    logic              w_idle_start;

    logic [63:0]       w_prod_s;
    logic [63:0]       w_prod_u;
    logic              w_div_signed;
    logic [31:0]       w_a_mag;
    logic [31:0]       w_b_mag;
    logic [31:0]       w_b_safe;
    logic [31:0]       w_uq;
    logic [31:0]       w_ur;
    logic [31:0]       w_res_hi;
    logic [31:0]       w_res_lo;
    logic              w_res_wr;

    // ------------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_is_arith = 1'b0;
        w_is_mult  = 1'b0;
        case (md_op)
            C_OP_MULT, C_OP_MULTU: begin
                w_is_arith = 1'b1;
                w_is_mult  = 1'b1;
            end
            C_OP_DIV, C_OP_DIVU: begin
                w_is_arith = 1'b1;
            end
            default: begin
                w_is_arith = 1'b0;
                w_is_mult  = 1'b0;
            end
        endcase
    end

    assign w_idle_start = start && (state_q == ST_IDLE);
    assign w_accept     = w_idle_start && w_is_arith;
    assign cnt_d        = cnt_q - C_ONE;

    // The issue-cycle term lets the hazard unit hold D before busy rises.
    assign stall_req = d_md_use & (busy_q | (start & w_is_arith));

    // ------------------------------------------------------------------------
    // Datapath: results from the latched operands
    // ------------------------------------------------------------------------
    assign w_prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide is done on magnitudes; 0x80000000 stays 0x80000000 as an
    // unsigned magnitude, which makes the overflow case fall out naturally.
    assign w_div_signed = (op_q == C_OP_DIV);
    assign w_a_mag      = (w_div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign w_b_mag      = (w_div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign w_b_safe     = (b_q == 32'd0) ? 32'd1 : w_b_mag;
    assign w_uq         = w_a_mag / w_b_safe;
    assign w_ur         = w_a_mag % w_b_safe;

    always_comb begin
        w_res_hi = hi_q;
        w_res_lo = lo_q;
        w_res_wr = 1'b0;
        case (op_q)
            C_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_wr = 1'b1;
            end
            C_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_wr = 1'b1;
            end
            C_OP_DIV: begin
                w_res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - w_uq) : w_uq;
                w_res_hi = a_q[31] ? (32'd0 - w_ur) : w_ur;
                w_res_wr = (b_q != 32'd0);
            end
            C_OP_DIVU: begin
                w_res_lo = w_uq;
                w_res_hi = w_ur;
                w_res_wr = (b_q != 32'd0);
            end
            default: begin
                w_res_hi = hi_q;
                w_res_lo = lo_q;
                w_res_wr = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        op_q    <= md_op;
                        a_q     <= rs_val;
                        b_q     <= rt_val;
                        cnt_q   <= w_is_mult ? C_MULT_N : C_DIV_N;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (w_idle_start && (md_op == C_OP_MTHI)) begin
                        hi_q <= rs_val;
                    end else if (w_idle_start && (md_op == C_OP_MTLO)) begin
                        lo_q <= rs_val;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    if (cnt_q <= C_ONE) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (w_res_wr) begin
                            hi_q <= w_res_hi;
                            lo_q <= w_res_lo;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
